mem_req_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the instruction-fetch requester (IF stage, read-only) and the data requester (EX issues, MEM collects `data_ok`). It arbitrates requests with data priority, holds a granted request stable until the memory accepts it, and tracks up to `OUTSTANDING` in-flight transactions in order. Responses are routed back to the requester that issued them. Responses belonging to transactions cancelled by a pipeline flush (`csr_reset`) are silently dropped.

---
 rtl/mem_req_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Memory port arbiter: data-priority grant between fetch and load/store,
// request hold until accept, and an in-order tracker that routes or drops responses.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_I,
        HOLD_D
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUTSTANDING-1:0] src_q, src_d;
    logic [OUTSTANDING-1:0] cxl_q, cxl_d;

    logic cancel_pending_q, cancel_pending_d;

    logic        hold_wr_q, hold_wr_d;
    logic [1:0]  hold_size_q, hold_size_d;
    logic [3:0]  hold_wstrb_q, hold_wstrb_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;

    logic can_grant;
    logic grant_d;
    logic grant_i;
    logic accept;
    logic push;
    logic pop;
    logic push_src;
    logic head_src;
    logic head_cxl;

    // A full tracker blocks grants on the registered count, so a pop frees room next cycle
    always_comb begin
        can_grant = (state_q == IDLE) && (count_q < MAX_CNT)
                    && !csr_reset && !reset;
        grant_d   = can_grant && data_req;
        grant_i   = can_grant && !data_req && inst_req;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        push_src  = 1'b0;
        if (state_q != IDLE) begin
            mem_req   = 1'b1;
            mem_wr    = hold_wr_q;
            mem_size  = hold_size_q;
            mem_wstrb = hold_wstrb_q;
            mem_addr  = hold_addr_q;
            mem_wdata = hold_wdata_q;
            push_src  = (state_q == HOLD_D);
        end else if (grant_d) begin
            mem_req   = 1'b1;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            push_src  = 1'b1;
        end else if (grant_i) begin
            mem_req   = 1'b1;
            mem_size  = 2'd2;
            mem_addr  = inst_addr;
        end
    end

    assign accept = mem_req & mem_addr_ok;
    assign push   = accept;
    assign pop    = mem_data_ok & (count_q != '0);

    assign inst_addr_ok = accept & ~push_src & ~cancel_pending_q;
    assign data_addr_ok = accept & push_src & ~cancel_pending_q;

    assign head_src = src_q[rd_ptr_q];
    assign head_cxl = cxl_q[rd_ptr_q];

    // A flush in the pop cycle must also drop the response
    assign inst_data_ok = pop & ~head_src & ~head_cxl & ~csr_reset;
    assign data_data_ok = pop & head_src & ~head_cxl & ~csr_reset;
    assign resp_rdata   = mem_rdata;

    always_comb begin
        src_d    = src_q;
        cxl_d    = cxl_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (csr_reset) begin
            cxl_d = '1;
        end
        if (push) begin
            src_d[wr_ptr_q] = push_src;
            cxl_d[wr_ptr_q] = cancel_pending_q | csr_reset;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d          = state_q;
        cancel_pending_d = cancel_pending_q;
        hold_wr_d        = hold_wr_q;
        hold_size_d      = hold_size_q;
        hold_wstrb_d     = hold_wstrb_q;
        hold_addr_d      = hold_addr_q;
        hold_wdata_d     = hold_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d || grant_i) begin
                    hold_wr_d    = mem_wr;
                    hold_size_d  = mem_size;
                    hold_wstrb_d = mem_wstrb;
                    hold_addr_d  = mem_addr;
                    hold_wdata_d = mem_wdata;
                    if (!mem_addr_ok) begin
                        state_d = grant_d ? HOLD_D : HOLD_I;
                    end
                end
            end
            HOLD_I, HOLD_D: begin
                if (mem_addr_ok) begin
                    state_d = IDLE;
                end else if (csr_reset) begin
                    cancel_pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cancel_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            src_q            <= '0;
            cxl_q            <= '0;
            cancel_pending_q <= 1'b0;
            hold_wr_q        <= 1'b0;
            hold_size_q      <= 2'd0;
            hold_wstrb_q     <= 4'd0;
            hold_addr_q      <= 32'd0;
            hold_wdata_q     <= 32'd0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            src_q            <= src_d;
            cxl_q            <= cxl_d;
            cancel_pending_q <= cancel_pending_d;
            hold_wr_q        <= hold_wr_d;
            hold_size_q      <= hold_size_d;
            hold_wstrb_q     <= hold_wstrb_d;
            hold_addr_q      <= hold_addr_d;
            hold_wdata_q     <= hold_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_req_arbiter;

    localparam int OUTS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_reset = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int total = 0;
    int bad = 0;

    mem_req_arbiter #(.OUTSTANDING(OUTS)) dut (
        .clk(clk), .reset(reset), .csr_reset(csr_reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%08h exp=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of issued transactions and one held request
    typedef struct packed {
        bit d;
        bit cx;
    } ent_t;

    ent_t        mq[$];
    ent_t        nq[$];
    bit          hv, hd, hpend;
    logic        hwr;
    logic [1:0]  hsz;
    logic [3:0]  hst;
    logic [31:0] ha, hwd;
    bit          n_hv, n_hd, n_hpend;
    logic        n_hwr;
    logic [1:0]  n_hsz;
    logic [3:0]  n_hst;
    logic [31:0] n_ha, n_hwd;

    always @(negedge clk) begin
        logic        e_req, e_wr, src, acc, pop;
        logic [1:0]  e_sz;
        logic [3:0]  e_st;
        logic [31:0] e_a, e_wd;
        logic        e_iao, e_dao, e_ido, e_ddo;
        ent_t        ne;
        e_req = 0; e_wr = 0; e_sz = 0; e_st = 0; e_a = 0; e_wd = 0;
        e_iao = 0; e_dao = 0; e_ido = 0; e_ddo = 0;
        src = 0; acc = 0; pop = 0;
        nq = mq;
        n_hv = hv; n_hd = hd; n_hpend = hpend;
        n_hwr = hwr; n_hsz = hsz; n_hst = hst; n_ha = ha; n_hwd = hwd;
        if (!reset) begin
            if (hv) begin
                e_req = 1; e_wr = hwr; e_sz = hsz; e_st = hst;
                e_a = ha; e_wd = hwd; src = hd;
            end else if (!csr_reset && mq.size() < OUTS) begin
                if (data_req) begin
                    e_req = 1; e_wr = data_wr; e_sz = data_size;
                    e_st = data_wstrb; e_a = data_addr; e_wd = data_wdata;
                    src = 1;
                end else if (inst_req) begin
                    e_req = 1; e_sz = 2; e_a = inst_addr;
                end
            end
            acc = e_req && mem_addr_ok;
            e_iao = acc && !src && !(hv && hpend);
            e_dao = acc && src && !(hv && hpend);
            pop = mem_data_ok && mq.size() > 0;
            if (pop) begin
                e_ido = !mq[0].d && !mq[0].cx && !csr_reset;
                e_ddo = mq[0].d && !mq[0].cx && !csr_reset;
                void'(nq.pop_front());
            end
            if (csr_reset)
                foreach (nq[i]) nq[i].cx = 1;
            if (acc) begin
                ne.d = src;
                ne.cx = (hv && hpend) || csr_reset;
                nq.push_back(ne);
            end
            if (hv) begin
                if (acc) n_hv = 0;
                else if (csr_reset) n_hpend = 1;
            end else if (e_req && !acc) begin
                n_hv = 1; n_hd = src; n_hpend = 0;
                n_hwr = e_wr; n_hsz = e_sz; n_hst = e_st;
                n_ha = e_a; n_hwd = e_wd;
            end
        end
        chk("m_mem_req", mem_req, e_req);
        chk("m_mem_wr", mem_wr, e_wr);
        chk("m_mem_size", mem_size, e_sz);
        chk("m_mem_wstrb", mem_wstrb, e_st);
        chk("m_mem_addr", mem_addr, e_a);
        chk("m_mem_wdata", mem_wdata, e_wd);
        chk("m_inst_addr_ok", inst_addr_ok, e_iao);
        chk("m_data_addr_ok", data_addr_ok, e_dao);
        chk("m_inst_data_ok", inst_data_ok, e_ido);
        chk("m_data_data_ok", data_data_ok, e_ddo);
        chk("m_resp_rdata", resp_rdata, mem_rdata);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            hv = 0; hd = 0; hpend = 0;
            hwr = 0; hsz = 0; hst = 0; ha = 0; hwd = 0;
        end else begin
            mq = nq;
            hv = n_hv; hd = n_hd; hpend = n_hpend;
            hwr = n_hwr; hsz = n_hsz; hst = n_hst; ha = n_ha; hwd = n_hwd;
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        csr_reset = 0; inst_req = 0; data_req = 0; data_wr = 0;
        data_size = 2; data_wstrb = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_iaok", inst_addr_ok, 0);
        chk("rst_daok", data_addr_ok, 0);
        chk("rst_mem_addr", mem_addr, 0);
        go(); reset = 0;

        // priority: data wins, inst next cycle
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_addr = 32'h80; mem_addr_ok = 1;
        @(negedge clk);
        chk("prio_daok", data_addr_ok, 1);
        chk("prio_iaok", inst_addr_ok, 0);
        chk("prio_addr", mem_addr, 32'h80);
        go(); data_req = 0;
        @(negedge clk);
        chk("prio_iaok2", inst_addr_ok, 1);
        chk("prio_addr2", mem_addr, 32'h1c000000);
        go(); clr(); mem_data_ok = 1; mem_rdata = 32'h11;
        @(negedge clk);
        chk("prio_ddok", data_data_ok, 1);
        go(); mem_rdata = 32'h22;
        @(negedge clk);
        chk("prio_idok", inst_data_ok, 1);
        go(); clr();

        // hold stability: store held three cycles while inst_req toggles
        data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hf;
        data_addr = 32'h1000; data_wdata = 32'hdeadbeef;
        for (int c = 1; c <= 4; c++) begin
            inst_req = c[0];
            mem_addr_ok = (c == 4);
            if (c > 1) begin
                data_addr = 32'h2000; data_wdata = 32'h0;
            end
            @(negedge clk);
            chk("hold_addr", mem_addr, 32'h1000);
            chk("hold_wdata", mem_wdata, 32'hdeadbeef);
            chk("hold_wr", mem_wr, 1);
            chk("hold_daok", data_addr_ok, (c == 4));
            go();
        end
        clr(); mem_data_ok = 1;
        @(negedge clk);
        chk("hold_ddok", data_data_ok, 1);
        go(); clr();

        // ordering with a full tracker
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        @(negedge clk);
        chk("ord_iaok", inst_addr_ok, 1);
        go(); inst_req = 0; data_req = 1; data_addr = 32'h80;
        @(negedge clk);
        chk("ord_daok", data_addr_ok, 1);
        go(); data_req = 0; inst_req = 1; inst_addr = 32'h1c000004;
        @(negedge clk);
        chk("ord_full_req", mem_req, 0);
        go(); mem_data_ok = 1; mem_rdata = 32'hAAAA;
        @(negedge clk);
        chk("ord_idok", inst_data_ok, 1);
        chk("ord_rdata1", resp_rdata, 32'hAAAA);
        chk("ord_wait_req", mem_req, 0);
        go(); mem_rdata = 32'h5555;
        @(negedge clk);
        chk("ord_ddok", data_data_ok, 1);
        chk("ord_idok_lo", inst_data_ok, 0);
        chk("ord_rdata2", resp_rdata, 32'h5555);
        chk("ord_third_ok", inst_addr_ok, 1);
        go(); inst_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        chk("ord_third_dok", inst_data_ok, 1);
        go(); clr();

        // flush with one in flight and one held inst request
        data_req = 1; data_addr = 32'h300; mem_addr_ok = 1;
        @(negedge clk);
        chk("fl_daok", data_addr_ok, 1);
        go(); data_req = 0; inst_req = 1; inst_addr = 32'h400;
        mem_addr_ok = 0;
        @(negedge clk);
        chk("fl_hold_req", mem_req, 1);
        go(); csr_reset = 1;
        @(negedge clk);
        chk("fl_req_stays", mem_req, 1);
        go(); csr_reset = 0; inst_req = 0; mem_addr_ok = 1;
        @(negedge clk);
        chk("fl_acc_addr", mem_addr, 32'h400);
        chk("fl_no_iaok", inst_addr_ok, 0);
        go(); mem_addr_ok = 0; mem_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_drop_i", inst_data_ok, 0);
            chk("fl_drop_d", data_data_ok, 0);
            go();
        end
        clr(); inst_req = 1; inst_addr = 32'h500; mem_addr_ok = 1;
        @(negedge clk);
        chk("fl_after_iaok", inst_addr_ok, 1);
        go(); clr(); mem_data_ok = 1;
        @(negedge clk);
        chk("fl_after_idok", inst_data_ok, 1);
        go(); clr();

        // flush and response in the same cycle
        inst_req = 1; inst_addr = 32'h600; mem_addr_ok = 1;
        go(); inst_req = 0; data_req = 1; data_addr = 32'h700;
        csr_reset = 1; mem_data_ok = 1;
        @(negedge clk);
        chk("fr_drop", inst_data_ok, 0);
        chk("fr_no_grant", mem_req, 0);
        go(); csr_reset = 0; mem_data_ok = 0;
        @(negedge clk);
        chk("fr_daok", data_addr_ok, 1);
        go(); clr(); mem_data_ok = 1;
        @(negedge clk);
        chk("fr_ddok", data_data_ok, 1);
        go(); clr();

        // async reset in the middle of a held store
        data_req = 1; data_wr = 1; data_addr = 32'h900; data_wstrb = 4'h3;
        @(negedge clk);
        chk("ar_req", mem_req, 1);
        go(); clr();
        #2 reset = 1;
        #1 chk("ar_req_lo", mem_req, 0);
        go(); reset = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("ar_stray_d", data_data_ok, 0);
        chk("ar_stray_i", inst_data_ok, 0);
        go(); clr();
        go();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
